tone_arbiter: RTL and testbench
===============================

TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2_000_000, silent cycles inserted between grants (minimum 1).
REQ-002 Parameter MAX_HOLD, default 100_000_000, cycles an owner may hold while another source waits (0 = no preemption).
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  per-source request: bit0 free play, bit1 auto play, bit2 learn prompt.
REQ-006 freq0, freq1, freq2  input  11 each  requested frequency code per source.
REQ-007 grant  output  3  one-hot owner of the tone generator, registered.
REQ-008 frequency  output  11  code to the tone generator, registered.
REQ-009 busy  output  1  high when state is not IDLE.
REQ-010 gap  output  1  high when state is GAP.

Function
REQ-011 The block SHALL have three states: IDLE, PLAY and GAP.
REQ-012 IDLE: grant=0, frequency=SILENCE; any req high -> PLAY, with the winner granted on the next edge (1-cycle req-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: search starts at (last_owner+1) mod 3 and wraps; the first set req bit wins.
REQ-014 PLAY: frequency SHALL follow freq[owner] with 1-cycle latency, including changes to a new note (legato, no gap).
REQ-015 PLAY with freq[owner]==SILENCE: output SILENCE, remain in PLAY, keep grant.
REQ-016 PLAY with req[owner] low: -> GAP, grant=0, frequency=SILENCE, gap counter loaded with GAP_CYCLES-1.
REQ-017 PLAY with MAX_HOLD!=0, another req pending and hold counter == MAX_HOLD-1: preempt and enter GAP as in REQ-016.
REQ-018 Hold counter SHALL reset on every grant; it counts only while another source is requesting and saturates at MAX_HOLD-1.
REQ-019 GAP: counter decrements each cycle; at 0 -> PLAY with the round-robin winner if any req is high, else -> IDLE.
REQ-020 Requests arriving during GAP SHALL NOT be granted before the gap expires.
REQ-021 If the owner drops req while another source raises req on the same edge, GAP SHALL still be inserted.
REQ-022 last_owner SHALL update on every grant.
REQ-023 Counter widths SHALL be $clog2 of the respective parameter, minimum 1 bit.
REQ-024 grant SHALL never have more than one bit set.

Reset
REQ-025 On reset low: state=IDLE, grant=0, frequency=SILENCE, both counters=0, last_owner=2, so source 0 wins first after reset.
REQ-026 Reset asserted mid-PLAY or mid-GAP SHALL clear outputs immediately, without waiting for clk.

Structure
REQ-027 SILENCE, the source index constants and the state encoding SHALL come from the shared parameters include file.
REQ-028 One sub-module, rr_pick3, SHALL be combinational (req, last_owner -> one-hot winner); it SHALL have no other logic.

Verification
Unless noted, GAP_CYCLES=4 and MAX_HOLD=8.
REQ-029 Reset release, req=001, freq0=0x106 -> grant=001 and frequency=0x106 one cycle later, busy=1.
REQ-030 Owner 0 changes freq0 0x106->0x126 -> frequency=0x126 next cycle, with no gap cycles.
REQ-031 Owner 0 drops req while req=010 rises the same cycle -> 4 cycles of grant=0, gap=1, frequency=SILENCE, then grant=010.
REQ-032 req=111 held continuously -> grants in the order 001, 010, 100, 001, each preempted after 8 cycles and separated by 4-cycle gaps.
REQ-033 MAX_HOLD=0, req=011 held -> grant stays 001 indefinitely.
REQ-034 reset pulsed low mid-GAP -> outputs clear immediately; next req=110 -> grant=010.

Source files
------------

// File: rtl/tone_arbiter_pkg.sv
// Shared constants, state encoding and small helpers for the tone arbiter.
// Frequency code 0 is reserved as silence for the tone generator.
package tone_arbiter_pkg;

  localparam int         FREQ_W    = 11;
  localparam logic [10:0] SILENCE  = 11'h000;

  localparam logic [1:0] SRC_FREE  = 2'd0;
  localparam logic [1:0] SRC_AUTO  = 2'd1;
  localparam logic [1:0] SRC_LEARN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[2])      return SRC_LEARN;
    else if (oh[1]) return SRC_AUTO;
    else            return SRC_FREE;
  endfunction

endpackage

// File: rtl/tone_arbiter_rr_pick3.sv
// Combinational three-way round-robin pick: search starts just after
// last_owner and wraps; the first asserted request wins (one-hot result).
module rr_pick3
  import tone_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_owner,
  output logic [2:0] winner
);

  always_comb begin
    winner = '0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (int'(last_owner) + 1 + k) % 3;
      if (winner == 3'b000 && req[idx]) winner[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Arbitrates three tone sources onto one tone generator, inserting a silent
// gap between owners and optionally preempting a long-holding owner.
module tone_arbiter
  import tone_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = 2_000_000,
  parameter int MAX_HOLD   = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [10:0] freq0,
  input  logic [10:0] freq1,
  input  logic [10:0] freq2,
  output logic [2:0]  grant,
  output logic [10:0] frequency,
  output logic        busy,
  output logic        gap
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 1) ? MAX_HOLD - 1 : 0);

  state_t      state_reg, state_next;
  logic [2:0]  grant_reg, grant_next;
  logic [10:0] freq_reg, freq_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [1:0]  last_owner_reg, last_owner_next;

  logic [2:0]  winner;
  logic [1:0]  win_idx;
  logic        others_waiting;
  logic        do_grant;
  logic [10:0] freq_sel [4];

  assign freq_sel[0] = freq0;
  assign freq_sel[1] = freq1;
  assign freq_sel[2] = freq2;
  assign freq_sel[3] = SILENCE;

  rr_pick3 u_pick (
    .req        (req),
    .last_owner (last_owner_reg),
    .winner     (winner)
  );

  assign win_idx        = onehot_to_idx(winner);
  assign others_waiting = |(req & ~grant_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      freq_reg       <= SILENCE;
      gap_cnt_reg    <= '0;
      hold_cnt_reg   <= '0;
      last_owner_reg <= SRC_LEARN;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      freq_reg       <= freq_next;
      gap_cnt_reg    <= gap_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      last_owner_reg <= last_owner_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    freq_next       = freq_reg;
    gap_cnt_next    = gap_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    last_owner_next = last_owner_reg;
    do_grant        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (|req) do_grant = 1'b1;
      end
      ST_PLAY: begin
        // last_owner_reg is the current owner while playing
        if (!req[last_owner_reg] ||
            (MAX_HOLD != 0 && others_waiting && hold_cnt_reg == HOLD_LAST)) begin
          state_next   = ST_GAP;
          grant_next   = '0;
          freq_next    = SILENCE;
          gap_cnt_next = GAP_LAST;
        end else begin
          freq_next = freq_sel[last_owner_reg];
          if (others_waiting && hold_cnt_reg != HOLD_LAST)
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == '0) begin
          if (|req) do_grant = 1'b1;
          else      state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        freq_next  = SILENCE;
      end
    endcase

    if (do_grant) begin
      state_next      = ST_PLAY;
      grant_next      = winner;
      last_owner_next = win_idx;
      freq_next       = freq_sel[win_idx];
      hold_cnt_next   = '0;
    end
  end

  assign grant     = grant_reg;
  assign frequency = freq_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign gap       = (state_reg == ST_GAP);

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed self-checking bench for tone_arbiter (GAP_CYCLES=4, MAX_HOLD=8),
// with a second instance using MAX_HOLD=0 for the no-preemption case.
module tb_tone_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [10:0] freq0, freq1, freq2;
  logic [2:0]  grant, grant_nh;
  logic [10:0] frequency, frequency_nh;
  logic        busy, busy_nh, gap, gap_nh;

  int checks = 0;
  int errors = 0;

  tone_arbiter #(.GAP_CYCLES(4), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .freq0(freq0), .freq1(freq1), .freq2(freq2),
    .grant(grant), .frequency(frequency), .busy(busy), .gap(gap)
  );

  tone_arbiter #(.GAP_CYCLES(4), .MAX_HOLD(0)) dut_nh (
    .clk(clk), .reset(reset), .req(req),
    .freq0(freq0), .freq1(freq1), .freq2(freq2),
    .grant(grant_nh), .frequency(frequency_nh), .busy(busy_nh), .gap(gap_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [10:0] f0, f1, f2;
    logic [2:0]  grant;
    logic [10:0] freq;
    logic        busy;
    logic        gap;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic [2:0] r, logic [10:0] a, logic [10:0] b, logic [10:0] c,
                              logic [2:0] g, logic [10:0] f, logic bz, logic gp);
    vec_t v;
    v.req = r; v.f0 = a; v.f1 = b; v.f2 = c;
    v.grant = g; v.freq = f; v.busy = bz; v.gap = gp;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    req   = 3'b000;
    tick();
    reset = 1'b1;
  endtask

  logic [2:0]  rr_order [4];
  logic [10:0] rr_freq  [4];

  initial begin
    reset = 1'b0; req = 3'b000; freq0 = '0; freq1 = '0; freq2 = '0;

    // req, f0, f1, f2 -> grant, frequency, busy, gap after the next edge
    vecs[0]  = mk(3'b001, 11'h106, 11'h000, 11'h000, 3'b001, 11'h106, 1, 0);
    vecs[1]  = mk(3'b001, 11'h126, 11'h000, 11'h000, 3'b001, 11'h126, 1, 0);
    vecs[2]  = mk(3'b001, 11'h126, 11'h000, 11'h000, 3'b001, 11'h126, 1, 0);
    vecs[3]  = mk(3'b001, 11'h000, 11'h000, 11'h000, 3'b001, 11'h000, 1, 0);
    vecs[4]  = mk(3'b001, 11'h126, 11'h000, 11'h000, 3'b001, 11'h126, 1, 0);
    vecs[5]  = mk(3'b010, 11'h126, 11'h200, 11'h000, 3'b000, 11'h000, 1, 1);
    vecs[6]  = mk(3'b010, 11'h126, 11'h200, 11'h000, 3'b000, 11'h000, 1, 1);
    vecs[7]  = mk(3'b010, 11'h126, 11'h200, 11'h000, 3'b000, 11'h000, 1, 1);
    vecs[8]  = mk(3'b010, 11'h126, 11'h200, 11'h000, 3'b000, 11'h000, 1, 1);
    vecs[9]  = mk(3'b010, 11'h126, 11'h200, 11'h000, 3'b010, 11'h200, 1, 0);
    vecs[10] = mk(3'b110, 11'h126, 11'h201, 11'h300, 3'b010, 11'h201, 1, 0);
    vecs[11] = mk(3'b000, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[12] = mk(3'b100, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[13] = mk(3'b100, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[14] = mk(3'b100, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[15] = mk(3'b100, 11'h126, 11'h201, 11'h300, 3'b100, 11'h300, 1, 0);
    vecs[16] = mk(3'b000, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[17] = mk(3'b000, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[18] = mk(3'b000, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[19] = mk(3'b000, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 1, 1);
    vecs[20] = mk(3'b000, 11'h126, 11'h201, 11'h300, 3'b000, 11'h000, 0, 0);
    vecs[21] = mk(3'b011, 11'h111, 11'h201, 11'h300, 3'b001, 11'h111, 1, 0);

    rr_order[0] = 3'b001; rr_order[1] = 3'b010; rr_order[2] = 3'b100; rr_order[3] = 3'b001;
    rr_freq[0]  = 11'h010; rr_freq[1] = 11'h020; rr_freq[2] = 11'h030; rr_freq[3] = 11'h010;

    // Reset state
    tick();
    tick();
    chk("reset_grant", grant, 0);
    chk("reset_freq", frequency, 0);
    chk("reset_busy", busy, 0);
    chk("reset_gap", gap, 0);
    $display("reset: grant=%b freq=0x%0h busy=%b gap=%b", grant, frequency, busy, gap);
    reset = 1'b1;

    // Table-driven sequence
    for (int i = 0; i < 22; i++) begin
      req = vecs[i].req; freq0 = vecs[i].f0; freq1 = vecs[i].f1; freq2 = vecs[i].f2;
      tick();
      $display("vec %0d: req=%b grant=%b freq=0x%0h busy=%b gap=%b",
               i, vecs[i].req, grant, frequency, busy, gap);
      chk($sformatf("vec%0d_grant", i), grant, vecs[i].grant);
      chk($sformatf("vec%0d_freq", i), frequency, vecs[i].freq);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_gap", i), gap, vecs[i].gap);
    end

    // Round-robin with preemption: req=111 held continuously
    pulse_reset();
    freq0 = 11'h010; freq1 = 11'h020; freq2 = 11'h030;
    req = 3'b111;
    for (int o = 0; o < 4; o++) begin
      int n;
      n = (o == 3) ? 1 : 8;
      for (int c = 0; c < n; c++) begin
        tick();
        chk($sformatf("rr%0d_c%0d_grant", o, c), grant, rr_order[o]);
        chk($sformatf("rr%0d_c%0d_freq", o, c), frequency, rr_freq[o]);
      end
      $display("rr owner %0d: grant=%b freq=0x%0h", o, grant, frequency);
      if (o < 3) begin
        for (int c = 0; c < 4; c++) begin
          tick();
          chk($sformatf("rr%0d_gap%0d_grant", o, c), grant, 0);
          chk($sformatf("rr%0d_gap%0d_gap", o, c), gap, 1);
        end
      end
    end

    // No preemption when MAX_HOLD=0
    pulse_reset();
    req = 3'b011;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk($sformatf("nohold_c%0d_grant", c), grant_nh, 1);
    end
    $display("nohold: grant=%b after 40 cycles with req=011", grant_nh);

    // Asynchronous reset mid-GAP
    pulse_reset();
    freq0 = 11'h155;
    req = 3'b001;
    tick();
    chk("arst_pre_grant", grant, 1);
    req = 3'b000;
    tick();
    tick();
    chk("arst_in_gap", gap, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_freq", frequency, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gap", gap, 0);
    $display("async reset mid-gap: grant=%b freq=0x%0h busy=%b gap=%b", grant, frequency, busy, gap);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = 3'b110;
    tick();
    chk("arst_next_grant", grant, 2);
    chk("arst_next_busy", busy, 1);
    $display("after reset req=110: grant=%b", grant);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
